// File: rtl/instr_loader.sv
`default_nettype none
// ==== instr_loader: assembles a little-endian byte stream (length, then words) into instruction-memory writes.
// ==== Define INSTR_LOADER_CKSUM_EN to require a trailing 8-bit payload checksum.  Rev 1.0
module instr_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              loading,
  output logic              done,
  output logic              error
);

`ifdef INSTR_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERR   = 3'd3,
    ST_CKSUM = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;
`endif

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       len_q;
  logic [23:0]       asm_q;
`ifdef INSTR_LOADER_CKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic        accept;
  logic        word_byte;
  logic [31:0] word;
  logic        last_word;

  always_comb begin
    rx_ready = 1'b0;
    loading  = 1'b0;
    case (state)
      ST_LEN, ST_DATA: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
      end
`ifdef INSTR_LOADER_CKSUM_EN
      ST_CKSUM: rx_ready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept    = rx_valid && rx_ready;
  // The 4th byte of a word completes it straight from the input, no extra register stage.
  assign word_byte = accept && loading && (byte_cnt == 2'd3);
  assign word      = {rx_data, asm_q};
  assign last_word = ({{(32-ADDR_W){1'b0}}, word_idx} == (len_q - 32'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_LEN;
      byte_cnt  <= 2'd0;
      word_idx  <= '0;
      len_q     <= 32'd0;
      asm_q     <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef INSTR_LOADER_CKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;

      if (accept && loading) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: ;
        endcase
      end

      case (state)
        ST_LEN: begin
          if (word_byte) begin
            len_q    <= word;
            word_idx <= '0;
            if (word == 32'd0) begin
`ifdef INSTR_LOADER_CKSUM_EN
              state <= ST_CKSUM;
`else
              state <= ST_DONE;
              done  <= 1'b1;
`endif
            end else if (word > 32'(DEPTH)) begin
              state <= ST_ERR;
              error <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
`ifdef INSTR_LOADER_CKSUM_EN
          if (accept) sum_q <= sum_q + rx_data;
`endif
          if (word_byte) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_idx;
            mem_wdata <= word;
            if (last_word) begin
              // done follows one cycle later (from ST_DONE) so the final write lands first.
`ifdef INSTR_LOADER_CKSUM_EN
              state <= ST_CKSUM;
`else
              state <= ST_DONE;
`endif
            end else begin
              word_idx <= word_idx + ADDR_W'(1);
            end
          end
        end

`ifdef INSTR_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (accept) begin
            if (rx_data == sum_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERR: begin
          if (reload) begin
            state    <= ST_LEN;
            done     <= 1'b0;
            error    <= 1'b0;
            byte_cnt <= 2'd0;
            word_idx <= '0;
            len_q    <= 32'd0;
            asm_q    <= 24'd0;
`ifdef INSTR_LOADER_CKSUM_EN
            sum_q    <= 8'd0;
`endif
          end else if (state == ST_DONE) begin
            done <= 1'b1;
          end
        end

        default: state <= ST_LEN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ==== tb_instr_loader: scoreboard bench for instr_loader (expected writes queued at drive time).  Rev 1.0
module tb_instr_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk      = 1'b0;
  logic              rstn     = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data  = 8'd0;
  logic              reload   = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              loading;
  logic              done;
  logic              error;

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] prog [DEPTH];
  logic [7:0]  sum = 8'd0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {63'd0, mem_we}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {58'd0, mem_addr}, {58'd0, mon_e.addr});
        check("wr_data", {32'd0, mem_wdata}, {32'd0, mon_e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit payload);
    rx_valid = 1'b1;
    rx_data  = b;
    if (payload) sum = sum + b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit payload);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], payload);
  endtask

  task automatic push_exp(input int idx, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(idx);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic load_prog(input int n);
    send_word(32'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      push_exp(i, prog[i]);
      send_word(prog[i], 1'b1);
    end
  endtask

  // Called at the negedge right after the final payload byte was accepted.
  task automatic finish_load(input string tag);
    check({tag, "_we_last"}, {63'd0, mem_we}, 64'd1);
    check({tag, "_done_early"}, {63'd0, done}, 64'd0);
`ifdef INSTR_LOADER_CKSUM_EN
    send_byte(sum, 1'b0);
    rx_valid = 1'b0;
`else
    idle(1);
`endif
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
    check({tag, "_loading"}, {63'd0, loading}, 64'd0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    sum    = 8'd0;
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
    check({tag, "_loading"}, {63'd0, loading}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
    check({tag, "_loading"}, {63'd0, loading}, 64'd1);
    check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_addr"}, {58'd0, mem_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Basic two-word load
    prog[0] = 32'h08C0_00EF;
    prog[1] = 32'hFE01_0113;
    load_prog(2);
    finish_load("basic");
    idle(2);
    check("basic_done_hold", {63'd0, done}, 64'd1);

    // Zero length
    do_reload("rl_zero");
    send_word(32'd0, 1'b0);
    rx_valid = 1'b0;
`ifdef INSTR_LOADER_CKSUM_EN
    check("zero_wait_cksum", {63'd0, done}, 64'd0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
`endif
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_we", {63'd0, mem_we}, 64'd0);
    check("zero_loading", {63'd0, loading}, 64'd0);

    // Oversize length (DEPTH+1)
    do_reload("rl_ovr");
    send_word(32'd65, 1'b0);
    rx_valid = 1'b0;
    check("ovr_error", {63'd0, error}, 64'd1);
    check("ovr_done", {63'd0, done}, 64'd0);
    check("ovr_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("ovr_loading", {63'd0, loading}, 64'd0);
    send_word(32'hDEAD_BEEF, 1'b0);
    idle(2);
    check("ovr_sticky", {63'd0, error}, 64'd1);
    do_reload("rl_after_ovr");

    // Largest legal length fills every address
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    load_prog(DEPTH);
    finish_load("full");
    do_reload("rl_full");

    // Gapped single-word stream
    prog[0] = 32'hA5C3_1E7F;
    send_word(32'd1, 1'b0);
    idle(2);
    push_exp(0, prog[0]);
    send_byte(8'h7F, 1'b1); idle(1);
    send_byte(8'h1E, 1'b1); idle(4);
    send_byte(8'hC3, 1'b1); idle(1);
    send_byte(8'hA5, 1'b1);
    finish_load("gap");
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("gap_done_ignore", {63'd0, done}, 64'd1);
    check("gap_we_ignore", {63'd0, mem_we}, 64'd0);

    // Reset mid-load
    do_reload("rl_rst");
    prog[0] = 32'h1122_3344;
    send_word(32'd3, 1'b0);
    push_exp(0, prog[0]);
    send_word(prog[0], 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h77, 1'b1);
    rx_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    sum  = 8'd0;
    @(negedge clk);
    prog[0] = 32'hCAFE_F00D;
    load_prog(1);
    finish_load("post_rst");

`ifdef INSTR_LOADER_CKSUM_EN
    // Checksum match then mismatch
    do_reload("rl_ck_ok");
    prog[0] = 32'h0403_0201;
    send_word(32'd1, 1'b0);
    push_exp(0, prog[0]);
    send_word(prog[0], 1'b1);
    send_byte(8'h0A, 1'b0);
    rx_valid = 1'b0;
    check("ck_ok_done", {63'd0, done}, 64'd1);
    check("ck_ok_error", {63'd0, error}, 64'd0);
    do_reload("rl_ck_bad");
    send_word(32'd1, 1'b0);
    push_exp(0, prog[0]);
    send_word(prog[0], 1'b1);
    send_byte(8'h0B, 1'b0);
    rx_valid = 1'b0;
    check("ck_bad_error", {63'd0, error}, 64'd1);
    check("ck_bad_done", {63'd0, done}, 64'd0);
`endif

    idle(3);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
